// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with exact fill count,
// programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
//
// Optional feature: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (head word presented on rd_data without rd_en; rd_en pops). Without it the
// read path is registered with one cycle of latency.
//
// Ports:
//   clk           single clock, all logic on posedge
//   reset         synchronous, active-high reset
//   wr_en/wr_data write request and data
//   full          no free entry
//   almost_full   fill_count >= AFULL_THRESH
//   rd_en         read request (pop in FWFT mode)
//   rd_data       read data
//   rd_valid      rd_data holds a valid popped/head word
//   empty         no stored entry
//   almost_empty  fill_count <= AEMPTY_THRESH
//   fill_count    stored entries, 0..DEPTH
//   overflow      one-cycle pulse after wr_en while full
//   underflow     one-cycle pulse after rd_en while empty
module sync_fifo_param #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 3,
    parameter int unsigned AFULL_THRESH  = 2**ADDR_W - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                full,
    output logic                almost_full,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDR_W:0]     fill_count,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Status decodes from registered pointers; the extra MSB separates full from empty.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_THRESH));
    assign fill_count   = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Pointers, fill count and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    // Storage array; not cleared by reset, but writes are blocked during it.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; valid whenever something is stored.
    assign rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign rd_valid = !w_empty;
`else
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // Registered read: data and a one-cycle valid follow an accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

endmodule
